scan_sequencer: RTL and testbench

SCAN_SEQUENCER -- requirements
Module: scan_sequencer

---
 rtl/scan_sequencer.sv | 170 +++++++++++++++++
 tb/tb_scan_sequencer.sv | 398 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/scan_sequencer.sv
// Scan sequencer: steps a 3-bit select code 0..7 with a programmable dwell per code,
// in continuous or single-pass mode. Optional skip mask enabled by macro SCAN_SKIP_EN.
`timescale 1ns/1ps

module scan_sequencer #(
    parameter int DWELL_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               stop,
    input  logic               mode,
    input  logic [DWELL_W-1:0] dwell,
`ifdef SCAN_SKIP_EN
    input  logic [7:0]         skip_mask,
`endif
    output logic [2:0]         sel,
    output logic               sel_valid,
    output logic               busy,
    output logic               done,
    output logic               wrap
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t             state, state_nxt;
    logic [2:0]         sel_nxt;
    logic               sel_valid_nxt;
    logic               busy_nxt;
    logic               done_nxt;
    logic               wrap_nxt;
    logic [DWELL_W-1:0] cnt, cnt_nxt;
    logic [DWELL_W-1:0] dwell_q, dwell_q_nxt;
    logic               mode_q, mode_q_nxt;
    logic [7:0]         mask;
    logic               all_masked;
    logic [2:0]         first_code;
    logic [2:0]         last_code;
    logic [2:0]         step_code;

`ifdef SCAN_SKIP_EN
    assign mask = skip_mask;
`else
    assign mask = 8'h00;
`endif

    function automatic logic [2:0] lowest_unmasked(input logic [7:0] m);
        logic [2:0] r;
        r = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (!m[i]) r = 3'(i);
        end
        return r;
    endfunction

    function automatic logic [2:0] highest_unmasked(input logic [7:0] m);
        logic [2:0] r;
        r = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (!m[i]) r = 3'(i);
        end
        return r;
    endfunction

    // Search forward in wrap order; if only the current code is left it steps onto itself.
    function automatic logic [2:0] next_unmasked(input logic [2:0] cur, input logic [7:0] m);
        logic [2:0] r;
        logic [2:0] c;
        logic       found;
        r     = cur;
        found = 1'b0;
        for (int i = 1; i < 8; i++) begin
            c = cur + 3'(i);
            if (!found && !m[c]) begin
                r     = c;
                found = 1'b1;
            end
        end
        return r;
    endfunction

    assign all_masked = &mask;
    assign first_code = lowest_unmasked(mask);
    assign last_code  = highest_unmasked(mask);
    assign step_code  = next_unmasked(sel, mask);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            sel       <= 3'd0;
            sel_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            wrap      <= 1'b0;
            cnt       <= '0;
            dwell_q   <= '0;
            mode_q    <= 1'b0;
        end else begin
            state     <= state_nxt;
            sel       <= sel_nxt;
            sel_valid <= sel_valid_nxt;
            busy      <= busy_nxt;
            done      <= done_nxt;
            wrap      <= wrap_nxt;
            cnt       <= cnt_nxt;
            dwell_q   <= dwell_q_nxt;
            mode_q    <= mode_q_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        sel_nxt       = sel;
        sel_valid_nxt = sel_valid;
        busy_nxt      = busy;
        done_nxt      = 1'b0;
        wrap_nxt      = 1'b0;
        cnt_nxt       = cnt;
        dwell_q_nxt   = dwell_q;
        mode_q_nxt    = mode_q;

        case (state)
            IDLE: begin
                sel_nxt       = 3'd0;
                sel_valid_nxt = 1'b0;
                busy_nxt      = 1'b0;
                if (start && !stop && !all_masked) begin
                    state_nxt     = RUN;
                    sel_nxt       = first_code;
                    sel_valid_nxt = 1'b1;
                    busy_nxt      = 1'b1;
                    cnt_nxt       = dwell;
                    dwell_q_nxt   = dwell;
                    mode_q_nxt    = mode;
                end
            end

            RUN: begin
                if (stop || all_masked) begin
                    state_nxt     = IDLE;
                    sel_nxt       = 3'd0;
                    sel_valid_nxt = 1'b0;
                    busy_nxt      = 1'b0;
                    cnt_nxt       = '0;
                end else if (cnt != '0) begin
                    cnt_nxt = cnt - DWELL_W'(1);
                end else if (mode_q && sel >= last_code) begin
                    state_nxt     = IDLE;
                    sel_nxt       = 3'd0;
                    sel_valid_nxt = 1'b0;
                    busy_nxt      = 1'b0;
                    done_nxt      = 1'b1;
                end else begin
                    // A step that does not move upward is the wrap from highest to lowest code.
                    sel_nxt  = step_code;
                    cnt_nxt  = dwell_q;
                    wrap_nxt = !mode_q && (step_code <= sel);
                end
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_scan_sequencer.sv
// Randomized self-checking bench for scan_sequencer against an elapsed-cycle reference model;
// skip-mask scenarios compile in when SCAN_SKIP_EN is defined.
`timescale 1ns/1ps

module tb_scan_sequencer;

    localparam int DWELL_W = 8;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic               start = 1'b0;
    logic               stop = 1'b0;
    logic               mode = 1'b0;
    logic [DWELL_W-1:0] dwell = '0;
    logic [7:0]         skip_mask = 8'h00;
    logic [2:0]         sel;
    logic               sel_valid;
    logic               busy;
    logic               done;
    logic               wrap;

    int checks = 0;
    int errors = 0;

    // Reference model: elapsed cycles since start, mapped onto the list of scanned codes.
    bit         m_run = 1'b0;
    bit         m_mode = 1'b0;
    int         m_k = 0;
    int         m_hold = 1;
    int         m_n = 1;
    int         m_per = 8;
    int         m_codes[8];
    logic [6:0] exp_vec = 7'd0;

    always #5 clk = ~clk;

    scan_sequencer #(.DWELL_W(DWELL_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .stop      (stop),
        .mode      (mode),
        .dwell     (dwell),
`ifdef SCAN_SKIP_EN
        .skip_mask (skip_mask),
`endif
        .sel       (sel),
        .sel_valid (sel_valid),
        .busy      (busy),
        .done      (done),
        .wrap      (wrap)
    );

    task automatic cycle();
        bit         e_done;
        bit         e_wrap;
        logic [2:0] ecode;
        @(posedge clk);
        e_done = 1'b0;
        e_wrap = 1'b0;
        if (rst) begin
            m_run = 1'b0;
        end else if (!m_run) begin
            if (start && !stop && skip_mask != 8'hFF) begin
                m_run  = 1'b1;
                m_k    = 0;
                m_mode = mode;
                m_hold = int'(dwell) + 1;
                m_n    = 0;
                for (int i = 0; i < 8; i++) begin
                    if (!skip_mask[i]) begin
                        m_codes[m_n] = i;
                        m_n++;
                    end
                end
                m_per = m_n * m_hold;
            end
        end else if (stop || skip_mask == 8'hFF) begin
            m_run = 1'b0;
        end else begin
            m_k++;
            if (m_mode && m_k == m_per) begin
                m_run  = 1'b0;
                e_done = 1'b1;
            end else if (!m_mode && (m_k % m_per) == 0) begin
                e_wrap = 1'b1;
            end
        end
        if (m_run) begin
            ecode   = 3'(m_codes[(m_k / m_hold) % m_n]);
            exp_vec = {ecode, 1'b1, 1'b1, 1'b0, e_wrap};
        end else begin
            exp_vec = {3'b000, 1'b0, 1'b0, e_done, 1'b0};
        end
        #1;
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        start = 1'b1;
        stop  = 1'b1;
        cycle();
        checks++;
        if ({sel, sel_valid, busy, done, wrap} !== 7'd0) begin
            errors++;
            $display("[TB] FAIL reset: got %b expected %b", {sel, sel_valid, busy, done, wrap}, 7'd0);
        end
        rst   = 1'b0;
        start = 1'b0;
        stop  = 1'b0;
        cycle();
        checks++;
        if ({sel, sel_valid, busy, done, wrap} !== exp_vec) begin
            errors++;
            $display("[TB] FAIL reset_idle: got %b expected %b", {sel, sel_valid, busy, done, wrap}, exp_vec);
        end
    endtask

    task automatic test_single_pass();
        int dones = 0;
        mode  = 1'b1;
        dwell = '0;
        start = 1'b1;
        cycle();
        start = 1'b0;
        for (int c = 0; c < 11; c++) begin
            checks++;
            if ({sel, sel_valid, busy, done, wrap} !== exp_vec) begin
                errors++;
                $display("[TB] FAIL single_pass cyc %0d: got %b expected %b", c, {sel, sel_valid, busy, done, wrap}, exp_vec);
            end
            if (done) dones++;
            cycle();
        end
        checks++;
        if (dones != 1) begin
            errors++;
            $display("[TB] FAIL single_pass_done_count: got %0d expected 1", dones);
        end
    endtask

    task automatic test_continuous();
        int wraps = 0;
        mode  = 1'b0;
        dwell = DWELL_W'(2);
        start = 1'b1;
        cycle();
        start = 1'b0;
        for (int c = 0; c < 80; c++) begin
            cycle();
            checks++;
            if ({sel, sel_valid, busy, done, wrap} !== exp_vec) begin
                errors++;
                $display("[TB] FAIL continuous cyc %0d: got %b expected %b", c, {sel, sel_valid, busy, done, wrap}, exp_vec);
            end
            if (wrap) wraps++;
        end
        checks++;
        if (wraps != 3) begin
            errors++;
            $display("[TB] FAIL continuous_wrap_count: got %0d expected 3", wraps);
        end
        stop = 1'b1;
        cycle();
        stop = 1'b0;
    endtask

    task automatic test_stop();
        bit reached = 1'b0;
        mode  = 1'($urandom_range(0, 1));
        dwell = DWELL_W'($urandom_range(0, 3));
        start = 1'b1;
        cycle();
        start = 1'b0;
        for (int c = 0; c < 200 && !reached; c++) begin
            if (m_run && exp_vec[6:4] == 3'd4) reached = 1'b1;
            else cycle();
        end
        checks++;
        if (!reached || sel !== 3'd4) begin
            errors++;
            $display("[TB] FAIL stop_reach_sel4: got sel %0d expected 4", sel);
        end
        stop = 1'b1;
        cycle();
        stop = 1'b0;
        checks++;
        if ({sel, sel_valid, busy, done, wrap} !== 7'd0 || exp_vec !== 7'd0) begin
            errors++;
            $display("[TB] FAIL stop: got %b expected %b", {sel, sel_valid, busy, done, wrap}, 7'd0);
        end
    endtask

    task automatic test_start_stop_and_reset();
        bit reached = 1'b0;
        start = 1'b1;
        stop  = 1'b1;
        for (int c = 0; c < 4; c++) begin
            cycle();
            checks++;
            if ({sel, sel_valid, busy, done, wrap} !== 7'd0) begin
                errors++;
                $display("[TB] FAIL start_stop_idle cyc %0d: got %b expected %b", c, {sel, sel_valid, busy, done, wrap}, 7'd0);
            end
        end
        stop  = 1'b0;
        mode  = 1'b0;
        dwell = DWELL_W'($urandom_range(0, 2));
        cycle();
        start = 1'b0;
        for (int c = 0; c < 200 && !reached; c++) begin
            if (m_run && exp_vec[6:4] == 3'd5) reached = 1'b1;
            else cycle();
        end
        checks++;
        if (!reached || sel !== 3'd5) begin
            errors++;
            $display("[TB] FAIL reset_reach_sel5: got sel %0d expected 5", sel);
        end
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        checks++;
        if ({sel, sel_valid, busy, done, wrap} !== 7'd0) begin
            errors++;
            $display("[TB] FAIL mid_scan_reset: got %b expected %b", {sel, sel_valid, busy, done, wrap}, 7'd0);
        end
    endtask

    task automatic test_dwell_change();
        mode  = 1'b0;
        dwell = DWELL_W'(2);
        start = 1'b1;
        cycle();
        for (int c = 0; c < 60; c++) begin
            dwell = DWELL_W'($urandom_range(0, 15));
            mode  = 1'($urandom_range(0, 1));
            start = 1'($urandom_range(0, 1));
            cycle();
            checks++;
            if ({sel, sel_valid, busy, done, wrap} !== exp_vec) begin
                errors++;
                $display("[TB] FAIL dwell_change cyc %0d: got %b expected %b", c, {sel, sel_valid, busy, done, wrap}, exp_vec);
            end
        end
        start = 1'b0;
        stop  = 1'b1;
        cycle();
        stop  = 1'b0;
    endtask

    task automatic test_restart();
        int dones = 0;
        mode  = 1'b1;
        dwell = DWELL_W'(1);
        start = 1'b1;
        for (int c = 0; c < 40; c++) begin
            cycle();
            checks++;
            if ({sel, sel_valid, busy, done, wrap} !== exp_vec) begin
                errors++;
                $display("[TB] FAIL restart cyc %0d: got %b expected %b", c, {sel, sel_valid, busy, done, wrap}, exp_vec);
            end
            if (done) dones++;
        end
        checks++;
        if (dones != 2) begin
            errors++;
            $display("[TB] FAIL restart_done_count: got %0d expected 2", dones);
        end
        start = 1'b0;
        stop  = 1'b1;
        cycle();
        stop  = 1'b0;
    endtask

    task automatic test_max_dwell();
        int dones = 0;
        mode  = 1'b1;
        dwell = {DWELL_W{1'b1}};
        start = 1'b1;
        cycle();
        start = 1'b0;
        for (int c = 0; c < 8 * 256 + 2; c++) begin
            cycle();
            checks++;
            if ({sel, sel_valid, busy, done, wrap} !== exp_vec) begin
                errors++;
                $display("[TB] FAIL max_dwell cyc %0d: got %b expected %b", c, {sel, sel_valid, busy, done, wrap}, exp_vec);
            end
            if (done) dones++;
        end
        checks++;
        if (dones != 1) begin
            errors++;
            $display("[TB] FAIL max_dwell_done_count: got %0d expected 1", dones);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 3000; c++) begin
            rst   = ($urandom_range(0, 199) == 0);
            start = ($urandom_range(0, 7) == 0);
            stop  = ($urandom_range(0, 39) == 0);
            mode  = 1'($urandom_range(0, 1));
            dwell = DWELL_W'($urandom_range(0, 3));
            cycle();
            checks++;
            if ({sel, sel_valid, busy, done, wrap} !== exp_vec) begin
                errors++;
                $display("[TB] FAIL random cyc %0d: got %b expected %b", c, {sel, sel_valid, busy, done, wrap}, exp_vec);
            end
        end
        rst   = 1'b0;
        start = 1'b0;
        stop  = 1'b0;
    endtask

`ifdef SCAN_SKIP_EN
    task automatic test_skip();
        logic [2:0] seen[$];
        logic [2:0] want[$];
        want = '{3'd1, 3'd3, 3'd4, 3'd6};
        skip_mask = 8'b1010_0101;
        mode  = 1'b1;
        dwell = '0;
        start = 1'b1;
        cycle();
        start = 1'b0;
        for (int c = 0; c < 8; c++) begin
            checks++;
            if ({sel, sel_valid, busy, done, wrap} !== exp_vec) begin
                errors++;
                $display("[TB] FAIL skip_pass cyc %0d: got %b expected %b", c, {sel, sel_valid, busy, done, wrap}, exp_vec);
            end
            if (sel_valid) seen.push_back(sel);
            cycle();
        end
        checks++;
        if (seen != want) begin
            errors++;
            $display("[TB] FAIL skip_sequence: got %p expected %p", seen, want);
        end
        skip_mask = 8'hFF;
        start = 1'b1;
        for (int c = 0; c < 4; c++) begin
            cycle();
            checks++;
            if ({sel, sel_valid, busy, done, wrap} !== 7'd0) begin
                errors++;
                $display("[TB] FAIL skip_all_masked cyc %0d: got %b expected %b", c, {sel, sel_valid, busy, done, wrap}, 7'd0);
            end
        end
        start = 1'b0;
        for (int s = 0; s < 6; s++) begin
            skip_mask = 8'($urandom_range(0, 254));
            mode  = 1'($urandom_range(0, 1));
            dwell = DWELL_W'($urandom_range(0, 2));
            start = 1'b1;
            for (int c = 0; c < 60; c++) begin
                cycle();
                start = 1'b0;
                checks++;
                if ({sel, sel_valid, busy, done, wrap} !== exp_vec) begin
                    errors++;
                    $display("[TB] FAIL skip_random s%0d cyc %0d: got %b expected %b", s, c, {sel, sel_valid, busy, done, wrap}, exp_vec);
                end
            end
            skip_mask = 8'hFF;
            cycle();
            checks++;
            if ({sel, sel_valid, busy, done, wrap} !== 7'd0) begin
                errors++;
                $display("[TB] FAIL skip_mask_stop s%0d: got %b expected %b", s, {sel, sel_valid, busy, done, wrap}, 7'd0);
            end
        end
        skip_mask = 8'h00;
    endtask
`endif

    initial begin
        test_reset();
        test_single_pass();
        test_continuous();
        test_stop();
        test_start_stop_and_reset();
        test_dwell_change();
        test_restart();
        test_max_dwell();
        test_random();
`ifdef SCAN_SKIP_EN
        test_skip();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
